// File: rtl/gpio_bank_cfg_ctrl.sv
// rtl/gpio_bank_cfg_ctrl.sv - GPIO bank direction loader / isolation sequencer (option: GPIO_CFG_CTRL_READBACK_EN)
module gpio_bank_cfg_ctrl #(
    parameter int NUM_IO        = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              CFG_EN,
    input  logic              CFG_SI,
    input  logic              RECFG,
    output logic              BUSY,
    output logic [NUM_IO-1:0] DIR,
    output logic              CONFIG_DONE,
    output logic              IO_ISOL_N,
    output logic              CFG_SO
);
    localparam int CW = $clog2(NUM_IO + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, ACTIVE} state_t;

    state_t            state, state_nxt;
    logic [NUM_IO-1:0] shadow, shadow_nxt, shifted, dir_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [SW-1:0]     scnt, scnt_nxt;
    logic              shift_take;

    // New bits enter at the top so pad 0 ends up at bit 0 after NUM_IO shifts.
    generate
        if (NUM_IO == 1) begin : g_shift_one
            assign shifted = CFG_SI;
        end else begin : g_shift_many
            assign shifted = {CFG_SI, shadow[NUM_IO-1:1]};
        end
    endgenerate

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        cnt_nxt    = cnt;
        scnt_nxt   = scnt;
        dir_nxt    = DIR;
        shift_take = 1'b0;
        case (state)
            IDLE, LOAD: begin
                if (CFG_EN) begin
                    shift_take = 1'b1;
                    shadow_nxt = shifted;
                    cnt_nxt    = (state == IDLE) ? CW'(1) : cnt + CW'(1);
                    if (cnt_nxt == CW'(NUM_IO)) begin
                        dir_nxt   = shifted;
                        cnt_nxt   = '0;
                        scnt_nxt  = '0;
                        state_nxt = SETTLE;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            SETTLE: begin
                scnt_nxt = scnt + SW'(1);
                if (scnt == SW'(SETTLE_CYCLES - 1))
                    state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (RECFG) begin
                    state_nxt = IDLE;
                    dir_nxt   = '1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state       <= IDLE;
            shadow      <= '1;
            DIR         <= '1;
            cnt         <= '0;
            scnt        <= '0;
            BUSY        <= 1'b0;
            CONFIG_DONE <= 1'b0;
            IO_ISOL_N   <= 1'b0;
        end else begin
            state       <= state_nxt;
            shadow      <= shadow_nxt;
            DIR         <= dir_nxt;
            cnt         <= cnt_nxt;
            scnt        <= scnt_nxt;
            BUSY        <= (state_nxt == LOAD) || (state_nxt == SETTLE);
            CONFIG_DONE <= (state_nxt == ACTIVE);
            IO_ISOL_N   <= (state_nxt == ACTIVE);
        end
    end

`ifdef GPIO_CFG_CTRL_READBACK_EN
    // Captures the bit falling off the bottom of the shadow on each accepted shift.
    logic so_q;
    always_ff @(posedge CK) begin
        if (RST)
            so_q <= 1'b0;
        else if (shift_take)
            so_q <= shadow[0];
    end
    assign CFG_SO = so_q;
`else
    logic unused_shift_take;
    assign unused_shift_take = shift_take;
    assign CFG_SO            = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_bank_cfg_ctrl.sv
// tb/tb_gpio_bank_cfg_ctrl.sv - randomized model-checked bench for gpio_bank_cfg_ctrl
module tb_gpio_bank_cfg_ctrl;
    localparam int N = 8;
    localparam int S = 4;

    logic         CK = 1'b0;
    logic         RST = 1'b1, CFG_EN = 1'b0, CFG_SI = 1'b0, RECFG = 1'b0;
    logic         BUSY, CONFIG_DONE, IO_ISOL_N, CFG_SO;
    logic [N-1:0] DIR;

    int total = 0;
    int passed = 0;
    bit started = 0;

    gpio_bank_cfg_ctrl #(.NUM_IO(N), .SETTLE_CYCLES(S)) dut (
        .CK(CK), .RST(RST), .CFG_EN(CFG_EN), .CFG_SI(CFG_SI), .RECFG(RECFG),
        .BUSY(BUSY), .DIR(DIR), .CONFIG_DONE(CONFIG_DONE), .IO_ISOL_N(IO_ISOL_N),
        .CFG_SO(CFG_SO)
    );

    always #5 CK = ~CK;

    // Model: bits received so far, edges elapsed since DIR was loaded, active flag.
    logic [N-1:0] m_dir, m_shadow;
    logic         m_so;
    int           m_nbits, m_age;
    bit           m_active;

    always @(posedge CK) begin
        if (RST) begin
            started  = 1;
            m_dir    = '1;
            m_shadow = '1;
            m_so     = 1'b0;
            m_nbits  = 0;
            m_age    = -1;
            m_active = 0;
        end else if (m_active) begin
            if (RECFG) begin
                m_active = 0;
                m_dir    = '1;
            end
        end else if (m_age >= 0) begin
            m_age = m_age + 1;
            if (m_age == S) begin
                m_active = 1;
                m_age    = -1;
            end
        end else if (CFG_EN) begin
`ifdef GPIO_CFG_CTRL_READBACK_EN
            m_so = m_shadow[0];
`endif
            m_shadow = (m_shadow >> 1) | (N'(CFG_SI) << (N - 1));
            m_nbits  = m_nbits + 1;
            if (m_nbits == N) begin
                m_dir   = m_shadow;
                m_nbits = 0;
                m_age   = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act === exp) passed = passed + 1;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge CK) begin
        if (started) begin
            chk("dir", 32'(DIR), 32'(m_dir));
            chk("busy", 32'(BUSY), 32'(m_nbits > 0 || m_age >= 0));
            chk("config_done", 32'(CONFIG_DONE), 32'(m_active));
            chk("io_isol_n", 32'(IO_ISOL_N), 32'(m_active));
            chk("cfg_so", 32'(CFG_SO), 32'(m_so));
        end
    end

    task automatic step(input logic r, input logic e, input logic si, input logic rc);
        RST = r; CFG_EN = e; CFG_SI = si; RECFG = rc;
        @(posedge CK);
        #1;
    endtask

    logic [N-1:0] stream;
    logic [N-1:0] so_seq;
    int           n;

    initial begin
        stream = 8'h85;  // bits sent pad 0 first: 1,0,1,0,0,0,0,1
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        // Back-to-back load, RECFG pulsed during settle must be ignored.
        n = 0;
        for (int i = 0; i < N; i++) begin
            step(0, 1, stream[i], 0);
            n++;
        end
        chk("t2_dir_literal", 32'(DIR), 32'h85);
        chk("t2_model_literal", 32'(m_dir), 32'h85);
        while (!CONFIG_DONE && n < 40) begin
            step(0, 0, 0, 1);
            n++;
        end
        chk("t2_done_latency", n, 12);
        chk("t2_busy_fell", 32'(BUSY), 0);
        step(0, 0, 0, 1);
        chk("t4_recfg_dir", 32'(DIR), 32'hFF);
        chk("t4_recfg_done", 32'(CONFIG_DONE), 0);
        chk("t4_recfg_isol", 32'(IO_ISOL_N), 0);

        // Same stream with a 3-cycle CFG_EN gap after bit 4.
        n = 0;
        for (int i = 0; i < N; i++) begin
            step(0, 1, stream[i], 0);
            n++;
            if (i == 3) begin
                for (int k = 0; k < 3; k++) begin
                    step(0, 0, 1, 0);
                    n++;
                end
            end
        end
        chk("t3_dir_literal", 32'(DIR), 32'h85);
        while (!CONFIG_DONE && n < 40) begin
            step(0, 0, 0, 0);
            n++;
        end
        chk("t3_done_latency", n, 15);

        // Shifting in ACTIVE is ignored.
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
        chk("t5_dir_hold", 32'(DIR), 32'h85);
        chk("t5_still_active", 32'(CONFIG_DONE), 1);

        // Readback of the previous word while loading zeros.
        step(0, 0, 0, 1);
        so_seq = '0;
        for (int i = 0; i < N; i++) begin
            step(0, 1, 0, 0);
            so_seq[i] = CFG_SO;
        end
        chk("t6_dir_zero", 32'(DIR), 32'h00);
`ifdef GPIO_CFG_CTRL_READBACK_EN
        chk("t6_readback", 32'(so_seq), 32'h85);
`else
        chk("t6_so_tied", 32'(so_seq), 32'h00);
`endif

        // Reset mid-LOAD.
        for (int i = 0; i < N; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        chk("t1_busy_before", 32'(BUSY), 1);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("t1_dir", 32'(DIR), 32'hFF);
        chk("t1_done", 32'(CONFIG_DONE), 0);
        chk("t1_isol", 32'(IO_ISOL_N), 0);
        chk("t1_busy", 32'(BUSY), 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
                 1'($urandom), ($urandom_range(0, 9) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
